mips_mc_control: RTL and testbench

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

---
 rtl/mips_mc_control.sv | 175 +++++++++++++++++
 tb/tb_mips_mc_control.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing the shared datapath,
// plus a retired-instruction counter.
module mips_mc_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic [2:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] alu_op_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] pc_src_c;
    logic       pc_en_c, ir_write_c, iord_c, mem_write_c;
    logic       reg_write_c, reg_dst_c, mem_to_reg_c;
    logic       funct_ok;
    logic [2:0] funct_op;
    logic       retire;

    always_comb begin
        funct_ok = 1'b1;
        funct_op = 3'b000;
        case (funct)
            6'b100000: funct_op = 3'b010;
            6'b100010: funct_op = 3'b110;
            6'b100100: funct_op = 3'b000;
            6'b100101: funct_op = 3'b001;
            6'b101010: funct_op = 3'b111;
            default:   funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = FETCH;
        alu_op_c     = 3'b000;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        pc_src_c     = 2'b00;
        pc_en_c      = 1'b0;
        ir_write_c   = 1'b0;
        iord_c       = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write_c  = 1'b1;
                pc_en_c     = 1'b1;
                alu_src_b_c = 2'b01;
                alu_op_c    = 3'b010;
                state_d     = DECODE;
            end
            DECODE: begin
                alu_src_b_c = 2'b11;
                alu_op_c    = 3'b010;
                case (opcode)
                    6'b100011,
                    6'b101011: state_d = MEMADR;
                    6'b000000: state_d = funct_ok ? EXEC : FETCH;
                    6'b000100: state_d = BRANCH;
                    6'b001000: state_d = ADDIEX;
                    6'b000010: state_d = JUMP;
                    default:   state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_op_c    = 3'b010;
                state_d     = (opcode == 6'b100011) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord_c  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
            end
            MEMWR: begin
                iord_c      = 1'b1;
                mem_write_c = 1'b1;
            end
            EXEC: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = funct_op;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
            end
            BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 3'b110;
                pc_src_c    = 2'b01;
                pc_en_c     = zero;
            end
            ADDIEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_op_c    = 3'b010;
                state_d     = ADDIWB;
            end
            ADDIWB: reg_write_c = 1'b1;
            JUMP: begin
                pc_src_c = 2'b10;
                pc_en_c  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    assign retire = (state_q == MEMWB)  || (state_q == MEMWR) ||
                    (state_q == ALUWB)  || (state_q == BRANCH) ||
                    (state_q == ADDIWB) || (state_q == JUMP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retired <= '0;
        else if (retire) retired <= retired + 1'b1;
    end

    // Reset must silence the datapath even though FETCH decodes non-zero.
    assign alu_op     = rst_n ? alu_op_c     : 3'b000;
    assign alu_src_a  = rst_n ? alu_src_a_c  : 1'b0;
    assign alu_src_b  = rst_n ? alu_src_b_c  : 2'b00;
    assign pc_src     = rst_n ? pc_src_c     : 2'b00;
    assign pc_en      = rst_n ? pc_en_c      : 1'b0;
    assign ir_write   = rst_n ? ir_write_c   : 1'b0;
    assign iord       = rst_n ? iord_c       : 1'b0;
    assign mem_write  = rst_n ? mem_write_c  : 1'b0;
    assign reg_write  = rst_n ? reg_write_c  : 1'b0;
    assign reg_dst    = rst_n ? reg_dst_c    : 1'b0;
    assign mem_to_reg = rst_n ? mem_to_reg_c : 1'b0;
    assign state      = rst_n ? state_q      : 4'd0;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: per-cycle state sequences,
// key control outputs, counter behaviour, async reset and wrap.
module tb_mips_mc_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;

    logic [2:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  pc_src;
    logic        pc_en, ir_write, iord, mem_write;
    logic        reg_write, reg_dst, mem_to_reg;
    logic [3:0]  state;
    logic [15:0] retired;

    logic [2:0]  alu_op4;
    logic        alu_src_a4;
    logic [1:0]  alu_src_b4;
    logic [1:0]  pc_src4;
    logic        pc_en4, ir_write4, iord4, mem_write4;
    logic        reg_write4, reg_dst4, mem_to_reg4;
    logic [3:0]  state4;
    logic [3:0]  retired4;

    int checks = 0;
    int errors = 0;

    logic [2:0] s_alu_op [16];
    logic [1:0] s_pc_src [16];
    logic       s_pc_en  [16];
    logic       s_rw     [16];
    logic       s_rdst   [16];
    logic       s_mtr    [16];
    int         rw_cnt;
    int         mw_cnt;

    always #5 clk = ~clk;

    mips_mc_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en),
        .ir_write(ir_write), .iord(iord), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .state(state), .retired(retired)
    );

    mips_mc_control #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .alu_op(alu_op4), .alu_src_a(alu_src_a4),
        .alu_src_b(alu_src_b4), .pc_src(pc_src4), .pc_en(pc_en4),
        .ir_write(ir_write4), .iord(iord4), .mem_write(mem_write4),
        .reg_write(reg_write4), .reg_dst(reg_dst4),
        .mem_to_reg(mem_to_reg4), .state(state4), .retired(retired4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // seq holds the expected state per cycle, one nibble each, cycle 0 lowest.
    task automatic run(input string tag, input logic [5:0] op,
                       input logic [5:0] fn, input logic z,
                       input int n, input logic [23:0] seq);
        opcode = op;
        funct  = fn;
        zero   = z;
        rw_cnt = 0;
        mw_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            s_alu_op[k] = 3'b000; s_pc_src[k] = 2'b00; s_pc_en[k] = 1'b0;
            s_rw[k] = 1'b0; s_rdst[k] = 1'b0; s_mtr[k] = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_st%0d", tag, i), {28'd0, state},
                {28'd0, seq[4*i +: 4]});
            s_alu_op[state] = alu_op;
            s_pc_src[state] = pc_src;
            s_pc_en[state]  = pc_en;
            s_rw[state]     = reg_write;
            s_rdst[state]   = reg_dst;
            s_mtr[state]    = mem_to_reg;
            rw_cnt += int'(reg_write);
            mw_cnt += int'(mem_write);
            step();
        end
        chk({tag, "_end"}, {28'd0, state}, 32'd0);
    endtask

    initial begin
        logic [5:0] fn_tab [4];
        logic [2:0] op_tab [4];
        fn_tab = '{6'b100000, 6'b100100, 6'b100101, 6'b101010};
        op_tab = '{3'b010, 3'b000, 3'b001, 3'b111};

        opcode = 6'b100011;
        #12;
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_retired", {16'd0, retired}, 32'd0);
        chk("rst_ir_write", {31'd0, ir_write}, 32'd0);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("rst_alu", {29'd0, alu_op, alu_src_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("fetch_outs", {27'd0, ir_write, pc_en, alu_src_b, alu_src_a},
            {27'd0, 1'b1, 1'b1, 2'b01, 1'b0});
        chk("fetch_alu_op", {29'd0, alu_op}, 32'd2);

        run("lw", 6'b100011, 6'd0, 1'b0, 5, 24'h043210);
        chk("lw_rw_cnt", rw_cnt, 1);
        chk("lw_rw_mtr_s4", {30'd0, s_rw[4], s_mtr[4]}, 32'd3);
        chk("lw_ret", {16'd0, retired}, 32'd1);

        run("sw", 6'b101011, 6'd0, 1'b0, 4, 24'h005210);
        chk("sw_mw_rw", {mw_cnt[15:0], rw_cnt[15:0]}, 32'h0001_0000);
        chk("sw_ret", {16'd0, retired}, 32'd2);

        run("sub", 6'b000000, 6'b100010, 1'b0, 4, 24'h007610);
        chk("sub_alu_op", {29'd0, s_alu_op[6]}, 32'd6);
        chk("sub_wb", {30'd0, s_rdst[7], s_rw[7]}, 32'd3);
        chk("sub_ret", {16'd0, retired}, 32'd3);

        for (int t = 0; t < 4; t++) begin
            run($sformatf("rt%0d", t), 6'b000000, fn_tab[t], 1'b0, 4,
                24'h007610);
            chk($sformatf("rt%0d_op", t), {29'd0, s_alu_op[6]},
                {29'd0, op_tab[t]});
        end
        chk("rt_ret", {16'd0, retired}, 32'd7);

        run("beq1", 6'b000100, 6'd0, 1'b1, 3, 24'h000810);
        chk("beq1_pc", {29'd0, s_pc_en[8], s_pc_src[8]}, 32'b101);
        chk("beq1_ret", {16'd0, retired}, 32'd8);
        run("beq0", 6'b000100, 6'd0, 1'b0, 3, 24'h000810);
        chk("beq0_pc", {29'd0, s_pc_en[8], s_pc_src[8]}, 32'b001);
        chk("beq0_ret", {16'd0, retired}, 32'd9);

        run("addi", 6'b001000, 6'd0, 1'b0, 4, 24'h00a910);
        chk("addi_rw", {30'd0, s_rw[10], s_rdst[10]}, 32'b10);
        chk("addi_ret", {16'd0, retired}, 32'd10);

        run("j", 6'b000010, 6'd0, 1'b0, 3, 24'h000b10);
        chk("j_pc", {29'd0, s_pc_en[11], s_pc_src[11]}, 32'b110);
        chk("j_ret", {16'd0, retired}, 32'd11);

        run("badop", 6'b111111, 6'd0, 1'b0, 2, 24'h000010);
        chk("badop_wr", {mw_cnt[15:0], rw_cnt[15:0]}, 32'd0);
        run("badfn", 6'b000000, 6'b000000, 1'b0, 2, 24'h000010);
        chk("badfn_wr", {mw_cnt[15:0], rw_cnt[15:0]}, 32'd0);
        chk("bad_ret", {16'd0, retired}, 32'd11);

        opcode = 6'b100011;
        step();
        step();
        step();
        chk("pre_rst_memrd", {31'd0, iord}, 32'd1);
        chk("pre_rst_state", {28'd0, state}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", {28'd0, state}, 32'd0);
        chk("mid_rst_outs", {21'd0, iord, ir_write, pc_en, mem_write,
                             reg_write, alu_op, alu_src_b}, 32'd0);
        chk("mid_rst_ret", {16'd0, retired}, 32'd0);
        chk("mid_rst_ret4", {28'd0, retired4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_fetch", {27'd0, ir_write, state}, {27'd0, 1'b1, 4'd0});

        for (int t = 0; t < 15; t++)
            run($sformatf("jw%0d", t), 6'b000010, 6'd0, 1'b0, 3,
                24'h000b10);
        chk("wrap_15", {28'd0, retired4}, 32'd15);
        run("jw15", 6'b000010, 6'd0, 1'b0, 3, 24'h000b10);
        chk("wrap_0", {28'd0, retired4}, 32'd0);
        chk("wide_16", {16'd0, retired}, 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
